// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking write-back data cache controller with LRU victim write-back and line refill.
// Optional hit/miss counters are compiled in with DCACHE_CTRL_PERF_EN.
module dcache_ctrl #(
    parameter int TAG_W = 23,
    parameter int IDX_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cpu_req_i,
    input  logic               cpu_we_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    output logic [31:0]        cpu_data_o,
    output logic               cpu_stall_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    output logic [255:0]       mem_data_o,
    input  logic [255:0]       mem_data_i,
    input  logic               mem_ack_i,
    output logic               sram_enable_o,
    output logic               sram_write_o,
    output logic [IDX_W-1:0]   sram_addr_o,
    output logic [TAG_W+1:0]   sram_tag_o,
    output logic [255:0]       sram_data_o,
    input  logic [TAG_W+1:0]   sram_tag_i,
    input  logic [255:0]       sram_data_i,
`ifdef DCACHE_CTRL_PERF_EN
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o,
`endif
    input  logic               sram_hit_i
);
    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, ALLOCATE, REFILL} state_t;
    state_t state_q, state_d;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W+1:0] vtag_q;
    logic [255:0] line_q, wline;
    logic idle, hit, miss, wr_hit, unused;
    logic [7:0] word_sel;
    assign unused = ^cpu_addr_i[1:0];
    assign idle = state_q == IDLE;
    assign hit = idle & cpu_req_i & sram_hit_i;
    assign miss = idle & cpu_req_i & ~sram_hit_i;
    assign wr_hit = hit & cpu_we_i;
    assign word_sel = {cpu_addr_i[4:2], 5'b0};
    // line_q holds the victim until write-back completes, then the refill line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tag_q <= '0;
            idx_q <= '0;
            vtag_q <= '0;
            line_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss) begin
                tag_q <= cpu_addr_i[31:IDX_W+5];
                idx_q <= cpu_addr_i[IDX_W+4:5];
                vtag_q <= sram_tag_i;
                line_q <= sram_data_i;
            end
            if (state_q == ALLOCATE && mem_ack_i) line_q <= mem_data_i;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = miss ? MISS : IDLE;
            MISS:      state_d = vtag_q[TAG_W+1:TAG_W] == 2'b11 ? WRITEBACK : ALLOCATE;
            WRITEBACK: state_d = mem_ack_i ? ALLOCATE : WRITEBACK;
            ALLOCATE:  state_d = mem_ack_i ? REFILL : ALLOCATE;
            REFILL:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end
    always_comb begin
        wline = sram_data_i;
        wline[word_sel +: 32] = cpu_data_i;
    end
    assign cpu_stall_o = ~idle | miss;
    assign cpu_data_o = hit ? sram_data_i[word_sel +: 32] : '0;
    assign mem_enable_o = state_q == WRITEBACK || state_q == ALLOCATE;
    assign mem_write_o = state_q == WRITEBACK;
    assign mem_addr_o = state_q == WRITEBACK ? {vtag_q[TAG_W-1:0], idx_q, 5'b0} :
                        state_q == ALLOCATE  ? {tag_q, idx_q, 5'b0} : '0;
    assign mem_data_o = line_q;
    assign sram_enable_o = (idle & cpu_req_i) | state_q == REFILL;
    assign sram_write_o = wr_hit | state_q == REFILL;
    assign sram_addr_o = idle ? cpu_addr_i[IDX_W+4:5] : idx_q;
    assign sram_tag_o = state_q == REFILL ? {2'b10, tag_q} :
                        (idle & cpu_req_i) ? {{2{wr_hit}}, cpu_addr_i[31:IDX_W+5]} : '0;
    assign sram_data_o = state_q == REFILL ? line_q : wr_hit ? wline : '0;
`ifdef DCACHE_CTRL_PERF_EN
    logic replay_q;
    // the first IDLE cycle after REFILL is the replayed request, not a new access
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            replay_q <= 1'b0;
            hit_cnt_o <= '0;
            miss_cnt_o <= '0;
        end else begin
            replay_q <= state_q == REFILL;
            if (hit && !replay_q && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed table of IDLE-state vectors plus hand-written miss, write-back, reset and ack sequences.
module tb_dcache_ctrl;
    logic clk_i = 0, rst_ni = 0;
    logic cpu_req_i = 0, cpu_we_i = 0, mem_ack_i = 0, sram_hit_i = 0;
    logic [31:0] cpu_addr_i = 0, cpu_data_i = 0, cpu_data_o, mem_addr_o;
    logic cpu_stall_o, mem_enable_o, mem_write_o, sram_enable_o, sram_write_o;
    logic [255:0] mem_data_o, mem_data_i = 0, sram_data_o, sram_data_i = 0;
    logic [3:0] sram_addr_o;
    logic [24:0] sram_tag_o, sram_tag_i = 0;
`ifdef DCACHE_CTRL_PERF_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif
    int checks = 0, errors = 0;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
        .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o), .sram_tag_i(sram_tag_i),
        .sram_data_i(sram_data_i),
`ifdef DCACHE_CTRL_PERF_EN
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
`endif
        .sram_hit_i(sram_hit_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk_i);
        #1;
    endtask

    typedef struct {
        logic req, we, hit;
        logic [31:0] addr, wdata;
        logic [24:0] tag_i;
        logic [255:0] line;
        logic stall, sen, swe;
        logic [31:0] rdata;
        logic [3:0] sidx;
        logic [24:0] stag;
        logic [255:0] sdata;
    } vec_t;

    vec_t v[6];
    logic [255:0] line_a, line_w, line_v, refill1, refill2, refill2_w, junk;

    initial begin
        for (int i = 0; i < 8; i++) begin
            line_a[i*32 +: 32] = 32'hA000_0000 + i;
            line_v[i*32 +: 32] = 32'hB000_0000 + i;
            refill1[i*32 +: 32] = 32'hC000_0000 + i;
            refill2[i*32 +: 32] = 32'hD000_0000 + i;
            junk[i*32 +: 32] = 32'hEEEE_EEEE;
        end
        line_a[63:32] = 32'hDEADBEEF;
        line_w = line_a;
        line_w[191:160] = 32'h12345678;
        refill2_w = refill2;
        refill2_w[63:32] = 32'hCAFEF00D;

        //        req we hit addr          wdata          tag_i    line    stall sen swe rdata          sidx  stag          sdata
        v[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0024, 32'h0, 25'h0, line_a, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 25'h0, 256'h0};
        v[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0024, 32'h0, 25'h0, line_a, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'h1, 25'h0, 256'h0};
        v[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_1F1C, 32'h0, 25'h0, line_a, 1'b0, 1'b1, 1'b0, 32'hA000_0007, 4'h8, 25'h000000F, 256'h0};
        v[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0234, 32'h12345678, 25'h0, line_a, 1'b0, 1'b1, 1'b1, 32'h0, 4'h1, 25'h1800001, line_w};
        v[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 25'h0, line_a, 1'b1, 1'b1, 1'b0, 32'h0, 4'h2, 25'h0, 256'h0};
        v[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0A48, 32'h1, 25'h0, line_a, 1'b1, 1'b1, 1'b0, 32'h0, 4'h2, 25'h0000005, 256'h0};

        #2;
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_mem_en", mem_enable_o, 0);
        chk("rst_mem_we", mem_write_o, 0);
        chk("rst_sram_en", sram_enable_o, 0);
        chk("rst_sram_we", sram_write_o, 0);
        chk("rst_cpu_data", cpu_data_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        @(negedge clk_i);
        rst_ni = 1;

        // requests are withdrawn before the next edge so table misses never start a refill
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            cpu_req_i = v[i].req; cpu_we_i = v[i].we; sram_hit_i = v[i].hit;
            cpu_addr_i = v[i].addr; cpu_data_i = v[i].wdata;
            sram_tag_i = v[i].tag_i; sram_data_i = v[i].line;
            #1;
            chk($sformatf("v%0d_stall", i), cpu_stall_o, v[i].stall);
            chk($sformatf("v%0d_sram_en", i), sram_enable_o, v[i].sen);
            chk($sformatf("v%0d_sram_we", i), sram_write_o, v[i].swe);
            chk($sformatf("v%0d_mem_en", i), mem_enable_o, 0);
            if (v[i].req) begin
                chk($sformatf("v%0d_sram_addr", i), sram_addr_o, v[i].sidx);
                chk($sformatf("v%0d_sram_tag", i), sram_tag_o, v[i].stag);
            end
            if (!(v[i].we && v[i].hit)) chk($sformatf("v%0d_rdata", i), cpu_data_o, v[i].rdata);
            if (v[i].swe) chk($sformatf("v%0d_sram_data", i), sram_data_o, v[i].sdata);
            #1;
            cpu_req_i = 0;
        end

        // clean read miss, ack three cycles after ALLOCATE starts
        @(negedge clk_i);
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h0000_1040; sram_hit_i = 0;
        sram_tag_i = {2'b10, 23'h33}; sram_data_i = line_v;
        #1 chk("a_miss_stall", cpu_stall_o, 1);
        settle();
        sram_data_i = junk; cpu_addr_i = 32'h0000_0000;
        chk("a_miss_stall2", cpu_stall_o, 1);
        chk("a_miss_mem_en", mem_enable_o, 0);
        settle();
        chk("a_alloc_en", mem_enable_o, 1);
        chk("a_alloc_we", mem_write_o, 0);
        chk("a_alloc_addr", mem_addr_o, 32'h0000_1040);
        settle();
        settle();
        chk("a_alloc_hold", mem_addr_o, 32'h0000_1040);
        mem_ack_i = 1; mem_data_i = refill1;
        settle();
        mem_ack_i = 0; mem_data_i = junk;
        chk("a_refill_we", sram_write_o, 1);
        chk("a_refill_idx", sram_addr_o, 4'h2);
        chk("a_refill_tag", sram_tag_o, {2'b10, 23'h8});
        chk("a_refill_data", sram_data_o, refill1);
        chk("a_refill_stall", cpu_stall_o, 1);
        cpu_addr_i = 32'h0000_1040; sram_hit_i = 1; sram_data_i = refill1; sram_tag_i = {2'b10, 23'h8};
        settle();
        chk("a_replay_stall", cpu_stall_o, 0);
        chk("a_replay_data", cpu_data_o, 32'hC000_0000);
        cpu_req_i = 0;

        // dirty write miss: write-back of the victim before the refill
        @(negedge clk_i);
        cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h0000_4064; cpu_data_i = 32'hCAFEF00D;
        sram_hit_i = 0; sram_tag_i = {2'b11, 23'h5}; sram_data_i = line_v;
        #1 chk("b_miss_swe", sram_write_o, 0);
        settle();
        sram_data_i = junk; sram_tag_i = 0;
        settle();
        chk("b_wb_en", mem_enable_o, 1);
        chk("b_wb_we", mem_write_o, 1);
        chk("b_wb_addr", mem_addr_o, 32'h0000_0A60);
        chk("b_wb_data", mem_data_o, line_v);
        mem_ack_i = 1;
        settle();
        mem_ack_i = 0;
        chk("b_alloc_we", mem_write_o, 0);
        chk("b_alloc_addr", mem_addr_o, 32'h0000_4060);
        mem_ack_i = 1; mem_data_i = refill2;
        settle();
        mem_ack_i = 0;
        chk("b_refill_tag", sram_tag_o, {2'b10, 23'h20});
        chk("b_refill_data", sram_data_o, refill2);
        sram_hit_i = 1; sram_data_i = refill2; sram_tag_i = {2'b10, 23'h20};
        settle();
        chk("b_replay_stall", cpu_stall_o, 0);
        chk("b_replay_swe", sram_write_o, 1);
        chk("b_replay_tag", sram_tag_o, {2'b11, 23'h20});
        chk("b_replay_data", sram_data_o, refill2_w);
        cpu_req_i = 0; cpu_we_i = 0;

        // ack during MISS is ignored; ack on the first ALLOCATE cycle completes
        @(negedge clk_i);
        cpu_req_i = 1; cpu_addr_i = 32'h0000_1040; sram_hit_i = 0; sram_tag_i = 0; sram_data_i = junk;
        settle();
        mem_ack_i = 1; mem_data_i = refill1;
        settle();
        mem_ack_i = 0;
        chk("d_alloc_after_miss_ack", mem_enable_o, 1);
        mem_ack_i = 1;
        settle();
        mem_ack_i = 0;
        chk("d_same_cycle_refill", sram_write_o, 1);
        chk("d_same_cycle_mem_en", mem_enable_o, 0);
        sram_hit_i = 1; sram_data_i = refill1;
        settle();
        chk("d_replay_stall", cpu_stall_o, 0);
        cpu_req_i = 0;

        // reset while a write-back is outstanding
        @(negedge clk_i);
        cpu_req_i = 1; cpu_addr_i = 32'h0000_4064; sram_hit_i = 0;
        sram_tag_i = {2'b11, 23'h5}; sram_data_i = line_v;
        settle();
        settle();
        chk("c_wb_en", mem_enable_o, 1);
        #1;
        rst_ni = 0; cpu_req_i = 0;
        #1;
        chk("c_rst_mem_en", mem_enable_o, 0);
        chk("c_rst_mem_we", mem_write_o, 0);
        chk("c_rst_mem_addr", mem_addr_o, 0);
        chk("c_rst_stall", cpu_stall_o, 0);
        @(negedge clk_i);
        rst_ni = 1; mem_ack_i = 1;
        settle();
        mem_ack_i = 0;
        chk("c_late_ack_mem_en", mem_enable_o, 0);
        chk("c_late_ack_sram_we", sram_write_o, 0);
        settle();
        chk("c_idle_mem_en", mem_enable_o, 0);

`ifdef DCACHE_CTRL_PERF_EN
        chk("p_rst_hits", hit_cnt_o, 0);
        chk("p_rst_misses", miss_cnt_o, 0);
        @(negedge clk_i);
        cpu_req_i = 1; cpu_we_i = 0; sram_hit_i = 1; cpu_addr_i = 32'h0000_0024; sram_data_i = line_a;
        @(negedge clk_i);
        cpu_addr_i = 32'h0000_1F1C;
        @(negedge clk_i);
        cpu_addr_i = 32'h0000_1040; sram_hit_i = 0; sram_tag_i = 0;
        settle();
        settle();
        mem_ack_i = 1; mem_data_i = refill1;
        settle();
        mem_ack_i = 0; sram_hit_i = 1; sram_data_i = refill1;
        settle();
        chk("p_replay_stall", cpu_stall_o, 0);
        @(negedge clk_i);
        cpu_req_i = 0;
        #1;
        chk("p_hits", hit_cnt_o, 2);
        chk("p_misses", miss_cnt_o, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 23, tag width; address = {tag[TAG_W-1:0], index[IDX_W-1:0], offset[4:0]}.
REQ-002 SHALL have parameter IDX_W, default 4, set-index width; TAG_W+IDX_W+5 SHALL equal 32.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  rising-edge clock.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 cpu_req_i  in  1  CPU access request; cpu_we_i  in  1  1=store, 0=load.
REQ-006 cpu_addr_i  in  32  byte address; cpu_data_i  in  32  store word.
REQ-007 cpu_data_o  out  32  load word; cpu_stall_o  out  1  CPU must hold request.
REQ-008 mem_enable_o  out  1  memory request; mem_write_o  out  1  1=line write-back.
REQ-009 mem_addr_o  out  32  line address, [4:0]=0; mem_data_o  out  256  write-back line.
REQ-010 mem_data_i  in  256  refill line; mem_ack_i  in  1  one-cycle completion pulse.
REQ-011 sram_enable_o  out  1; sram_write_o  out  1; sram_addr_o  out  IDX_W  set index.
REQ-012 sram_tag_o  out  TAG_W+2  {valid, dirty, tag}; sram_data_o  out  256  line to write.
REQ-013 sram_tag_i  in  TAG_W+2  hit line tag, or LRU victim tag on miss; sram_data_i  in  256  matching line/victim; sram_hit_i  in  1  combinational hit.

Function
REQ-014 SHALL implement FSM states IDLE, MISS, WRITEBACK, ALLOCATE, REFILL.
REQ-015 IDLE with cpu_req_i=1: sram_enable_o=1, sram_addr_o=cpu_addr_i[8:5], sram_tag_o={2'b00, cpu_addr_i[31:9]}.
REQ-016 IDLE read hit: cpu_stall_o=0 same cycle; cpu_data_o=word cpu_addr_i[4:2] of sram_data_i, combinational, zero extra latency.
REQ-017 IDLE write hit: same cycle sram_write_o=1, sram_data_o=sram_data_i with word [4:2] replaced by cpu_data_i, sram_tag_o={1,1,tag}, cpu_stall_o=0.
REQ-018 IDLE miss: cpu_stall_o=1 combinationally; latch addr, we, data and victim tag/data; next state MISS.
REQ-019 MISS: victim valid and dirty (bits [TAG_W+1:TAG_W]=2'b11) -> WRITEBACK; else -> ALLOCATE.
REQ-020 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim data, held stable until mem_ack_i; on ack -> ALLOCATE.
REQ-021 ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={latched tag, index, 5'b0}, held until mem_ack_i; on ack latch mem_data_i -> REFILL.
REQ-022 REFILL: one cycle sram_enable_o=1, sram_write_o=1, sram_tag_o={1, 0, tag}, sram_data_o=refill line; -> IDLE.
REQ-023 After REFILL the held CPU request replays in IDLE and hits; stall drops on that hit cycle (miss-to-release: MISS + memory cycles + REFILL + 1).
REQ-024 cpu_stall_o SHALL be 1 in every state except IDLE; cpu_addr_i/cpu_data_i changes outside IDLE SHALL be ignored.
REQ-025 mem_ack_i in IDLE, MISS or REFILL SHALL be ignored; mem_ack_i in the same cycle as mem_enable_o first rises SHALL complete the transfer.
REQ-026 IDLE with cpu_req_i=0: all sram_*, mem_* enables 0, cpu_stall_o=0.

Reset
REQ-027 rst_ni=0 SHALL immediately force state IDLE and clear all latched registers regardless of state, abandoning any outstanding memory transfer.
REQ-028 During and after reset until a request: cpu_stall_o=0, mem_enable_o=0, mem_write_o=0, sram_enable_o=0, sram_write_o=0, cpu_data_o=0, mem_addr_o=0.

Configuration
REQ-029 Macro DCACHE_CTRL_PERF_EN defined: outputs hit_cnt_o[31:0] and miss_cnt_o[31:0] SHALL exist, reset to 0; hit_cnt_o increments on each IDLE first-attempt hit, miss_cnt_o on each IDLE miss; replay hits not counted; both saturate at 32'hFFFFFFFF.
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 Read hit: sram_hit_i=1, addr 0x0000_0024, line word1=0xDEADBEEF -> cpu_data_o=0xDEADBEEF, cpu_stall_o=0 same cycle, no mem_enable_o.
REQ-032 Clean read miss, addr 0x0000_1040, ack 3 cycles later -> ALLOCATE mem_addr_o=0x0000_1040, REFILL tag {1,0,0x8}, index 2; replay hits, stall released.
REQ-033 Dirty write miss, victim tag {1,1,0x5} index 3 -> WRITEBACK mem_addr_o=0x0000_0A60 with victim data, then ALLOCATE, REFILL, replayed write sets dirty bit.
REQ-034 Reset asserted in WRITEBACK before ack -> mem_enable_o=0 and state IDLE immediately; later ack ignored.
REQ-035 Same-cycle ack: mem_ack_i=1 on first ALLOCATE cycle -> REFILL next cycle.
REQ-036 With DCACHE_CTRL_PERF_EN: 2 hits + 1 miss -> hit_cnt_o=2, miss_cnt_o=1.
